bpsk_tx_sequencer: RTL and testbench



---
 rtl/bpsk_tx_sequencer.sv | 174 +++++++++++++++++
 tb/tb_bpsk_tx_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_tx_sequencer.sv
// rtl/bpsk_tx_sequencer.sv - BPSK modulator frame sequencer: payload FIFO, slot counters, priming/preamble framing
// Optional BPSK_SEQ_DIFF_EN: differentially encode payload words as they are loaded into mod_data.
module bpsk_tx_sequencer #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int PREAMBLE_WORDS = 2,
  parameter logic [DATA_WIDTH-1:0] PREAMBLE_WORD = 12'hAAA,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD = 12'h000
) (
  input  logic                             clk,
  input  logic                             arstn,
  input  logic [DATA_WIDTH-1:0]            s_data,
  input  logic                             s_last,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic                             mod_en,
  output logic [$clog2(SAMPLE_NUMBER)-1:0] mod_cnt,
  output logic [DATA_WIDTH-1:0]            mod_data,
  output logic                             mod_load,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             underrun,
  input  logic                             underrun_clr
);
  localparam int CW = $clog2(SAMPLE_NUMBER);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(PREAMBLE_WORDS + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_NUMBER - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_WIDTH - 1);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_WORDS - 1);
  localparam logic [PW-1:0] PRE_INIT = PW'((PREAMBLE_WORDS > 0) ? PREAMBLE_WORDS - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_PREAMBLE, S_PAYLOAD, S_LAST} state_t;
  typedef enum logic [1:0] {LD_NONE, LD_PRE, LD_POP, LD_IDLE} load_t;

  state_t state, next_state;
  load_t load;
  logic [BW-1:0] bit_cnt;
  logic [PW-1:0] pre_slot, pre_left;
  logic last_flag;
  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop, fifo_empty, start, head_last;
  logic [DATA_WIDTH-1:0] head_data, pop_word;

  assign fifo_empty = (fifo_level == '0);
  assign s_ready = (fifo_level != FULL_LEVEL);
  assign push = s_valid && s_ready;
  assign pop = (load == LD_POP);
  assign {head_last, head_data} = mem[rd_ptr];
  assign mod_en = (state != S_IDLE);
  assign busy = mod_en;
  assign mod_load = mod_en && (mod_cnt == CNT_MAX) && (bit_cnt == BIT_MAX);
  assign start = (state == S_IDLE) && !fifo_empty;

`ifdef BPSK_SEQ_DIFF_EN
  logic chain;

  function automatic logic [DATA_WIDTH-1:0] diff_encode(input logic [DATA_WIDTH-1:0] d, input logic prev);
    logic [DATA_WIDTH-1:0] e;
    logic p;
    p = prev;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      e[i] = d[i] ^ p;
      p = e[i];
    end
    return e;
  endfunction

  // chain restarts every frame, including a pop taken on the IDLE->PRIME edge
  assign pop_word = diff_encode(head_data, start ? 1'b0 : chain);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) chain <= 1'b0;
    else if (pop) chain <= pop_word[DATA_WIDTH-1];
    else if (start) chain <= 1'b0;
  end
`else
  assign pop_word = head_data;
`endif

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state <= S_IDLE;
    else state <= next_state;
  end

  // Loads run one slot ahead of the state: a boundary loads the word for the slot after next.
  always_comb begin
    next_state = state;
    load = LD_NONE;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_PRIME;
          load = (PREAMBLE_WORDS > 0) ? LD_PRE : LD_POP;
        end
      end
      S_PRIME, S_PREAMBLE, S_PAYLOAD: begin
        if (mod_load) begin
          if (last_flag) load = LD_NONE;
          else if (pre_left != '0) load = LD_PRE;
          else if (!fifo_empty) load = LD_POP;
          else load = LD_IDLE;
          if (state == S_PRIME && PREAMBLE_WORDS > 0) next_state = S_PREAMBLE;
          else if (state == S_PREAMBLE && pre_slot != PRE_LAST) next_state = S_PREAMBLE;
          else next_state = last_flag ? S_LAST : S_PAYLOAD;
        end
      end
      S_LAST: begin
        if (mod_load) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_last, s_data};
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      mod_cnt <= '0;
      bit_cnt <= '0;
      pre_slot <= '0;
      pre_left <= '0;
      last_flag <= 1'b0;
      mod_data <= '0;
      underrun <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
    end else begin
      if (state == S_IDLE) begin
        mod_cnt <= '0;
        bit_cnt <= '0;
      end else if (mod_cnt == CNT_MAX) begin
        mod_cnt <= '0;
        bit_cnt <= (bit_cnt == BIT_MAX) ? '0 : bit_cnt + 1'b1;
      end else begin
        mod_cnt <= mod_cnt + 1'b1;
      end

      if (start) begin
        pre_left <= PRE_INIT;
        pre_slot <= '0;
        last_flag <= 1'b0;
      end else begin
        if (mod_load && state == S_PREAMBLE) pre_slot <= pre_slot + 1'b1;
        if (load == LD_PRE) pre_left <= pre_left - 1'b1;
      end

      case (load)
        LD_PRE: mod_data <= PREAMBLE_WORD;
        LD_POP: begin
          mod_data <= pop_word;
          last_flag <= head_last;
        end
        LD_IDLE: mod_data <= IDLE_WORD;
        default: ;
      endcase

      if (load == LD_IDLE) underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;
    end
  end
endmodule

// File: tb/tb_bpsk_tx_sequencer.sv
// tb/tb_bpsk_tx_sequencer.sv - scoreboard bench for bpsk_tx_sequencer (4 samples/bit, 4-bit words)
// Runs with or without BPSK_SEQ_DIFF_EN; a second instance covers PREAMBLE_WORDS=0.
`timescale 1ns/1ps
module tb_bpsk_tx_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arstn, underrun_clr;
  logic [3:0] s_data, s_data0;
  logic s_last, s_valid, s_last0, s_valid0;
  logic s_ready, mod_en, mod_load, busy, underrun;
  logic s_ready0, mod_en0, mod_load0, busy0, underrun0;
  logic [1:0] mod_cnt, mod_cnt0;
  logic [3:0] mod_data, mod_data0;
  logic [2:0] fifo_level, fifo_level0;

  bpsk_tx_sequencer #(.SAMPLE_NUMBER(4), .DATA_WIDTH(4), .FIFO_DEPTH(4), .PREAMBLE_WORDS(1),
                      .PREAMBLE_WORD(4'hA), .IDLE_WORD(4'h0)) dut (
    .clk(clk), .arstn(arstn), .s_data(s_data), .s_last(s_last), .s_valid(s_valid),
    .s_ready(s_ready), .mod_en(mod_en), .mod_cnt(mod_cnt), .mod_data(mod_data),
    .mod_load(mod_load), .busy(busy), .fifo_level(fifo_level), .underrun(underrun),
    .underrun_clr(underrun_clr));

  bpsk_tx_sequencer #(.SAMPLE_NUMBER(4), .DATA_WIDTH(4), .FIFO_DEPTH(4), .PREAMBLE_WORDS(0),
                      .PREAMBLE_WORD(4'hA), .IDLE_WORD(4'h0)) dut0 (
    .clk(clk), .arstn(arstn), .s_data(s_data0), .s_last(s_last0), .s_valid(s_valid0),
    .s_ready(s_ready0), .mod_en(mod_en0), .mod_cnt(mod_cnt0), .mod_data(mod_data0),
    .mod_load(mod_load0), .busy(busy0), .fifo_level(fifo_level0), .underrun(underrun0),
    .underrun_clr(1'b0));

`ifdef BPSK_SEQ_DIFF_EN
  localparam logic [3:0] D1 = 4'b1111, D2 = 4'b1111, D9 = 4'b0111;
`else
  localparam logic [3:0] D1 = 4'b0001, D2 = 4'b0000, D9 = 4'b1001;
`endif

  int n_cmp = 0, n_fail = 0;
  logic [3:0] sb_q[$], sb0_q[$];
  int len_q[$], len0_q[$];
  int run_len = 0, run_len0 = 0, load_seen = 0;
  logic chain_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // expected payload word; encoding modelled as prefix parity of the word XOR the chain bit
  function automatic logic [3:0] enc(input logic [3:0] d);
`ifdef BPSK_SEQ_DIFF_EN
    logic [3:0] e;
    logic [3:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask = 4'((5'd2 << i) - 5'd1);
      e[i] = (^(d & mask)) ^ chain_m;
    end
    chain_m = e[3];
    return e;
`else
    return d;
`endif
  endfunction

  always @(negedge clk) begin
    if (!arstn) begin
      run_len = 0;
      run_len0 = 0;
    end else begin
      if (mod_load) begin
        load_seen++;
        if (sb_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL sb_unexpected_load: mod_data %0h, no load expected", mod_data);
        end else check("sb_mod_data", mod_data, sb_q.pop_front());
      end
      if (mod_load0) begin
        if (sb0_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL sb0_unexpected_load: mod_data %0h, no load expected", mod_data0);
        end else check("sb0_mod_data", mod_data0, sb0_q.pop_front());
      end
      if (mod_en) run_len++;
      else if (run_len != 0) begin
        if (len_q.size() != 0) check("frame_len", run_len, len_q.pop_front());
        run_len = 0;
      end
      if (mod_en0) run_len0++;
      else if (run_len0 != 0) begin
        if (len0_q.size() != 0) check("frame0_len", run_len0, len0_q.pop_front());
        run_len0 = 0;
      end
    end
  end

  task automatic push(input bit sel, input logic [3:0] d, input bit l);
    int w;
    w = 0;
    @(negedge clk);
    if (sel) begin s_valid0 = 1'b1; s_data0 = d; s_last0 = l; end
    else begin s_valid = 1'b1; s_data = d; s_last = l; end
    while (!(sel ? s_ready0 : s_ready) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL push_timeout: s_ready 0 for 200 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_valid0 = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((busy || busy0) && w < 300);
    check("frame_end_busy", {busy, busy0}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200us, expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] e;
    int w;
    arstn = 1'b0; underrun_clr = 1'b0;
    s_data = '0; s_last = 1'b0; s_valid = 1'b0;
    s_data0 = '0; s_last0 = 1'b0; s_valid0 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mod_en", mod_en, 0);
    check("rst_mod_cnt", mod_cnt, 0);
    check("rst_mod_data", mod_data, 0);
    check("rst_mod_load", mod_load, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_fifo_level", fifo_level, 0);
    arstn = 1'b1;

    // frame 1: 3, 5(last)
    chain_m = 1'b0;
    sb_q.push_back(4'hA); sb_q.push_back(enc(4'h3));
    e = enc(4'h5); sb_q.push_back(e); sb_q.push_back(e);
    len_q.push_back(64);
    push(0, 4'h3, 0);
    @(negedge clk);
    check("en_before_start", mod_en, 0);
    check("level_one", fifo_level, 1);
    @(negedge clk);
    check("en_rise", mod_en, 1);
    push(0, 4'h5, 1);
    wait_idle();

    // frame 2: underrun then late last word
    chain_m = 1'b0;
    sb_q.push_back(4'hA); sb_q.push_back(enc(4'h3)); sb_q.push_back(4'h0);
    e = enc(4'h7); sb_q.push_back(e); sb_q.push_back(e);
    len_q.push_back(80);
    push(0, 4'h3, 0);
    w = 0;
    do begin @(negedge clk); w++; end while (!underrun && w < 200);
    check("underrun_set", underrun, 1);
    check("underrun_idle_word", mod_data, 4'h0);
    push(0, 4'h7, 1);
    wait_idle();
    check("underrun_sticky", underrun, 1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("underrun_cleared", underrun, 0);

    // frame 3: FIFO full and back-pressure
    chain_m = 1'b0;
    sb_q.push_back(4'hA);
    for (int i = 1; i <= 4; i++) sb_q.push_back(enc(4'(i)));
    e = enc(4'h5); sb_q.push_back(e); sb_q.push_back(e);
    len_q.push_back(112);
    for (int i = 1; i <= 4; i++) push(0, 4'(i), 0);
    @(negedge clk);
    check("full_s_ready", s_ready, 0);
    check("full_level", fifo_level, 4);
    push(0, 4'h5, 1);
    @(negedge clk);
    check("refill_level", fifo_level, 4);
    check("refill_s_ready", s_ready, 0);
    wait_idle();
    check("no_underrun", underrun, 0);

    // frame 4: reset mid-payload
    chain_m = 1'b0;
    sb_q.push_back(4'hA); sb_q.push_back(enc(4'h1));
    w = load_seen + 2;
    push(0, 4'h1, 0); push(0, 4'h2, 0); push(0, 4'h3, 0);
    for (int i = 0; i < 200 && load_seen < w; i++) @(negedge clk);
    for (int i = 0; i < 20 && mod_cnt != 2'd2; i++) @(negedge clk);
    check("pre_reset_cnt", mod_cnt, 2);
    #2 arstn = 1'b0;
    #1;
    check("arst_mod_en", mod_en, 0);
    check("arst_mod_cnt", mod_cnt, 0);
    check("arst_mod_data", mod_data, 0);
    check("arst_busy", busy, 0);
    check("arst_fifo_level", fifo_level, 0);
    check("arst_s_ready", s_ready, 1);
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {busy, fifo_level}, 4'b0000);

    // frame 5: encoding vector
    sb_q.push_back(4'hA); sb_q.push_back(D1); sb_q.push_back(D2); sb_q.push_back(D2);
    len_q.push_back(64);
    push(0, 4'b0001, 0);
    push(0, 4'b0000, 1);
    wait_idle();

    // no-preamble instance: single last word
    sb0_q.push_back(D9); sb0_q.push_back(D9);
    len0_q.push_back(32);
    push(1, 4'h9, 1);
    @(negedge clk);
    check("p0_en_before_start", mod_en0, 0);
    @(negedge clk);
    check("p0_first_data", mod_data0, D9);
    check("p0_popped", fifo_level0, 0);
    check("p0_en", mod_en0, 1);
    wait_idle();

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    check("sb0_drained", sb0_q.size(), 0);
    check("len_drained", len_q.size(), 0);
    check("len0_drained", len0_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
